// File: rtl/waveform_pkg.sv
// Shared constants for the waveform generator family: mode encodings and the
// direction flag of the triangle/square phase engine.
package waveform_pkg;

  localparam logic [1:0] MODE_TRI    = 2'd0;
  localparam logic [1:0] MODE_SAW_UP = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_SAW_DN = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/prescaler_tick.sv
// Free-running tick divider: asserts tick once every prescaler+1 cycles.
// clr holds the count at zero and suppresses the tick.
module prescaler_tick #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  // >= rather than == so a prescaler lowered below the count ticks at once
  // instead of running the counter round the full range.
  assign tick = !clr && (cnt_q >= prescaler);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/waveform_gen.sv
// Multi-mode waveform generator: triangle, rising/falling saw and square up to a
// programmable amplitude, with programmable step and output rate.
module waveform_gen
  import waveform_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned STEP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic [DATA_W-1:0]  amplitude,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [STEP_W-1:0]  step,
  output logic [DATA_W-1:0]  data,
  output logic               upd,
  output logic               period
);

  logic [1:0]        mode_q;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0] data_d;
  logic              wrap;
  logic              mode_chg;
  logic              tick;

  logic [DATA_W:0]   s_ext, amp_ext, ph_ext, sum;

  assign mode_chg = ena && (mode != mode_q);

  prescaler_tick #(
    .PRESC_W (PRESC_W)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!ena || mode_chg),
    .prescaler (prescaler),
    .tick      (tick)
  );

  // One extra bit so data+s can never wrap before being compared.
  assign s_ext   = (step == '0) ? (DATA_W+1)'(1) : (DATA_W+1)'(step);
  assign amp_ext = {1'b0, amplitude};
  assign ph_ext  = {1'b0, phase_q};
  assign sum     = ph_ext + s_ext;

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    wrap    = 1'b0;
    case (mode_q)
      MODE_TRI, MODE_SQUARE: begin
        if (dir_q == DIR_UP) begin
          if (sum >= amp_ext) begin
            phase_d = amplitude;
            dir_d   = DIR_DN;
          end else begin
            phase_d = sum[DATA_W-1:0];
          end
        end else begin
          if (ph_ext <= s_ext) begin
            phase_d = '0;
            dir_d   = DIR_UP;
            wrap    = 1'b1;
          end else begin
            phase_d = phase_q - s_ext[DATA_W-1:0];
          end
        end
      end
      MODE_SAW_UP: begin
        if (sum > amp_ext) begin
          phase_d = '0;
          wrap    = 1'b1;
        end else begin
          phase_d = sum[DATA_W-1:0];
        end
      end
      default: begin // MODE_SAW_DN
        if (phase_q == '0) begin
          phase_d = amplitude;
          wrap    = 1'b1;
        end else if (ph_ext <= s_ext) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q - s_ext[DATA_W-1:0];
        end
      end
    endcase
  end

  // Square follows the direction of the phase engine, so its rising edge
  // coincides with the period strobe.
  always_comb begin
    data_d = phase_d;
    if (mode_q == MODE_SQUARE) begin
      data_d = (dir_d == DIR_UP) ? amplitude : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_TRI;
      phase_q <= '0;
      dir_q   <= DIR_UP;
      data    <= '0;
      upd     <= 1'b0;
      period  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (!ena) begin
        phase_q <= '0;
        dir_q   <= DIR_UP;
        data    <= '0;
        upd     <= 1'b0;
        period  <= 1'b0;
      end else if (mode_chg) begin
        phase_q <= '0;
        dir_q   <= DIR_UP;
        data    <= '0;
        upd     <= 1'b1;
        period  <= 1'b1;
      end else if (tick) begin
        phase_q <= phase_d;
        dir_q   <= dir_d;
        data    <= data_d;
        upd     <= 1'b1;
        period  <= wrap;
      end else begin
        upd     <= 1'b0;
        period  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_gen.sv
// Directed bench for waveform_gen: per-cycle vector table plus hand-written
// sequences for clamp, square symmetry, mode change and reset/enable clears.
module tb_waveform_gen;

  localparam logic [1:0] TRI = 2'd0, SUP = 2'd1, SQR = 2'd2, SDN = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [1:0]  mode;
  logic [15:0] amplitude;
  logic [15:0] prescaler;
  logic [7:0]  step;
  logic [15:0] data;
  logic        upd;
  logic        period;

  int n_tests = 0;
  int n_fail  = 0;

  waveform_gen #(
    .DATA_W  (16),
    .PRESC_W (16),
    .STEP_W  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .amplitude (amplitude),
    .prescaler (prescaler),
    .step      (step),
    .data      (data),
    .upd       (upd),
    .period    (period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [1:0]  mode;
    logic [15:0] amp;
    logic [15:0] presc;
    logic [7:0]  step;
    logic [15:0] e_data;
    logic        e_upd;
    logic        e_period;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] p, input logic [7:0] s, input logic [15:0] d,
                     input logic u, input logic pr);
    vecs.push_back('{en, m, a, p, s, d, u, pr});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] m, input logic [15:0] a,
                       input logic [15:0] p, input logic [7:0] s);
    ena = en; mode = m; amplitude = a; prescaler = p; step = s;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input logic [15:0] d, input logic u,
                         input logic p);
    check({name, ".data"}, data, d);
    check({name, ".upd"}, upd, u);
    check({name, ".period"}, period, p);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit, highs, bad, pers;
    logic [15:0] prev;

    rst_n = 1'b0;
    drive(1'b0, TRI, 16'd0, 16'd0, 8'd1);
    #12;
    expect3("reset", 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // TRI amp=4 step=1 presc=0
    add(1, TRI, 4, 0, 1, 1, 1, 0); add(1, TRI, 4, 0, 1, 2, 1, 0);
    add(1, TRI, 4, 0, 1, 3, 1, 0); add(1, TRI, 4, 0, 1, 4, 1, 0);
    add(1, TRI, 4, 0, 1, 3, 1, 0); add(1, TRI, 4, 0, 1, 2, 1, 0);
    add(1, TRI, 4, 0, 1, 1, 1, 0); add(1, TRI, 4, 0, 1, 0, 1, 1);
    add(1, TRI, 4, 0, 1, 1, 1, 0);
    // SAW_UP amp=10 step=3 presc=2
    add(0, SUP, 10, 2, 3, 0, 0, 0);
    add(1, SUP, 10, 2, 3, 0, 0, 0); add(1, SUP, 10, 2, 3, 0, 0, 0);
    add(1, SUP, 10, 2, 3, 3, 1, 0); add(1, SUP, 10, 2, 3, 3, 0, 0);
    add(1, SUP, 10, 2, 3, 3, 0, 0); add(1, SUP, 10, 2, 3, 6, 1, 0);
    add(1, SUP, 10, 2, 3, 6, 0, 0); add(1, SUP, 10, 2, 3, 6, 0, 0);
    add(1, SUP, 10, 2, 3, 9, 1, 0); add(1, SUP, 10, 2, 3, 9, 0, 0);
    add(1, SUP, 10, 2, 3, 9, 0, 0); add(1, SUP, 10, 2, 3, 0, 1, 1);
    add(1, SUP, 10, 2, 3, 0, 0, 0); add(1, SUP, 10, 2, 3, 0, 0, 0);
    add(1, SUP, 10, 2, 3, 3, 1, 0);
    // SAW_DN amp=5 step=2 presc=0
    add(0, SDN, 5, 0, 2, 0, 0, 0);
    add(1, SDN, 5, 0, 2, 5, 1, 1); add(1, SDN, 5, 0, 2, 3, 1, 0);
    add(1, SDN, 5, 0, 2, 1, 1, 0); add(1, SDN, 5, 0, 2, 0, 1, 0);
    add(1, SDN, 5, 0, 2, 5, 1, 1);
    // step=0 behaves as 1
    add(0, SUP, 2, 0, 0, 0, 0, 0);
    add(1, SUP, 2, 0, 0, 1, 1, 0); add(1, SUP, 2, 0, 0, 2, 1, 0);
    add(1, SUP, 2, 0, 0, 0, 1, 1);
    // amplitude=0: TRI flips each tick, saw strobes period each tick
    add(0, TRI, 0, 0, 1, 0, 0, 0);
    add(1, TRI, 0, 0, 1, 0, 1, 0); add(1, TRI, 0, 0, 1, 0, 1, 1);
    add(1, TRI, 0, 0, 1, 0, 1, 0);
    add(0, SUP, 0, 0, 1, 0, 0, 0);
    add(1, SUP, 0, 0, 1, 0, 1, 1); add(1, SUP, 0, 0, 1, 0, 1, 1);
    // small SQUARE amp=4 step=2
    add(0, SQR, 4, 0, 2, 0, 0, 0);
    add(1, SQR, 4, 0, 2, 4, 1, 0); add(1, SQR, 4, 0, 2, 0, 1, 0);
    add(1, SQR, 4, 0, 2, 0, 1, 0); add(1, SQR, 4, 0, 2, 4, 1, 1);
    add(1, SQR, 4, 0, 2, 4, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ena, vecs[i].mode, vecs[i].amp, vecs[i].presc, vecs[i].step);
      clk1();
      expect3($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_upd, vecs[i].e_period);
    end

    // TRI full scale: must clamp to 0xFFFF exactly on tick 512
    drive(1'b0, TRI, 16'hFFFF, 16'd0, 8'h80);
    clk1();
    drive(1'b1, TRI, 16'hFFFF, 16'd0, 8'h80);
    hit = 0;
    prev = 16'd0;
    for (int i = 1; i <= 600; i++) begin
      clk1();
      if (data == 16'hFFFF) begin
        hit = i;
        break;
      end
      prev = data;
    end
    check("tri_peak_tick", hit, 512);
    check("tri_pre_peak", prev, 16'hFF80);

    // SQUARE full scale: equal halves over one 1024-tick period
    drive(1'b0, SQR, 16'hFFFF, 16'd0, 8'h80);
    clk1();
    drive(1'b1, SQR, 16'hFFFF, 16'd0, 8'h80);
    highs = 0; bad = 0; pers = 0;
    for (int i = 0; i < 1024; i++) begin
      clk1();
      if (data == 16'hFFFF) highs++;
      else if (data != 16'h0000) bad++;
      if (period) pers++;
    end
    check("sqr_high_count", highs, 512);
    check("sqr_bad_levels", bad, 0);
    check("sqr_period_count", pers, 1);

    // Mode change TRI -> SAW_UP at data=7
    drive(1'b0, TRI, 16'd20, 16'd0, 8'd1);
    clk1();
    drive(1'b1, TRI, 16'd20, 16'd0, 8'd1);
    repeat (7) clk1();
    check("mc_pre", data, 7);
    mode = SUP;
    clk1(); expect3("mc_restart", 16'd0, 1'b1, 1'b1);
    clk1(); expect3("mc_ramp1", 16'd1, 1'b1, 1'b0);
    clk1(); expect3("mc_ramp2", 16'd2, 1'b1, 1'b0);

    // Back to TRI, then lower amplitude below data while rising
    mode = TRI;
    clk1(); expect3("mc_tri", 16'd0, 1'b1, 1'b1);
    repeat (4) clk1();
    check("clamp_pre", data, 4);
    amplitude = 16'd2;
    clk1(); check("clamp_hit", data, 2);
    clk1(); check("clamp_down", data, 1);

    // Async reset mid-ramp, then ena low for one cycle
    drive(1'b0, TRI, 16'd100, 16'd0, 8'd5);
    clk1();
    drive(1'b1, TRI, 16'd100, 16'd0, 8'd5);
    repeat (4) clk1();
    check("rst_pre", data, 20);
    #2 rst_n = 1'b0;
    #1 expect3("rst_async", 16'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    clk1(); expect3("rst_restart", 16'd5, 1'b1, 1'b0);
    clk1(); check("ena_pre", data, 10);
    ena = 1'b0;
    clk1(); expect3("ena_clear", 16'd0, 1'b0, 1'b0);
    ena = 1'b1;
    clk1(); expect3("ena_restart", 16'd5, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
